rdma_rc_send_sched: RTL and testbench
=====================================

RDMA_RC_SEND_SCHED -- requirements
Module: rdma_rc_send_sched

Interface
REQ-001 SHALL have parameter NUM_QP, default 4, number of requesting QPs (power of two, 2..8).
REQ-002 SHALL have parameter CREDIT_WIDTH, default 8, per-QP credit counter width.
REQ-003 SHALL have parameter CREDIT_INIT, default 8'h10, per-QP credit value after reset.
REQ-004 SHALL have parameter STALL_TIMEOUT, default 4'd10, stall cycles before error (watchdog only).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port qp_req  input  NUM_QP  per-QP data frame pending.
REQ-008 SHALL have port qp_rts  input  NUM_QP  per-QP in RTS state and ready.
REQ-009 SHALL have port ack_valid  input  1  ACK control frame received; returns one credit.
REQ-010 SHALL have port ack_qp  input  log2(NUM_QP)  QP index of the ACK.
REQ-011 SHALL have port tx_valid  output  1  data frame send request to PDU path.
REQ-012 SHALL have port tx_qp  output  log2(NUM_QP)  QP index of the current send.
REQ-013 SHALL have port tx_ready  input  1  PDU path accepts the send.
REQ-014 SHALL have port grant  output  NUM_QP  one-hot copy of tx_qp while tx_valid, else 0.
REQ-015 SHALL have port credit_remain  output  NUM_QP*CREDIT_WIDTH  packed per-QP credits; QP i at bits [i*CREDIT_WIDTH +: CREDIT_WIDTH].
REQ-016 SHALL have port qp_pause  output  NUM_QP  per-QP credit exhausted.
REQ-017 SHALL have port sched_err  output  NUM_QP  per-QP stall timeout error.

Function
REQ-018 Eligibility: QP i SHALL be eligible iff qp_req[i] && qp_rts[i] && credit[i] != 0.
REQ-019 FSM SHALL have two states: IDLE and SEND; reset state is IDLE.
REQ-020 IDLE: if any QP is eligible, SHALL pick the winner round-robin starting at rr_ptr, register tx_qp, set tx_valid=1 next cycle, go to SEND; else stay in IDLE.
REQ-021 Latency: eligibility in cycle N SHALL give tx_valid=1 in cycle N+1.
REQ-022 SEND: tx_valid and tx_qp SHALL hold stable until tx_valid && tx_ready; qp_req/qp_rts changes SHALL NOT withdraw the request.
REQ-023 Handshake cycle: SHALL decrement credit[tx_qp] by 1, set rr_ptr = tx_qp+1 (mod NUM_QP), deassert tx_valid next cycle, return to IDLE. Minimum spacing is one send per 2 cycles.
REQ-024 ACK: if ack_valid && qp_rts[ack_qp], SHALL increment credit[ack_qp] by 1, saturating at all-ones; ACK with qp_rts[ack_qp]=0 SHALL be ignored.
REQ-025 Same-cycle handshake and accepted ACK on the same QP SHALL leave that credit unchanged.
REQ-026 Credit SHALL never decrement below 0; a wrap from 0 to all-ones is a design error.
REQ-027 qp_pause[i] SHALL be a register: 1 the cycle after credit[i] becomes 0, 0 the cycle after it becomes nonzero.
REQ-028 rr_ptr SHALL advance only on handshake; an idle or blocked QP keeps its turn.

Reset
REQ-029 On rst: state=IDLE, tx_valid=0, tx_qp=0, grant=0, rr_ptr=0, every credit=CREDIT_INIT, qp_pause=0, sched_err=0, stall counters=0.
REQ-030 rst asserted mid-SEND SHALL drop tx_valid immediately and discard the pending send; credit is not decremented.

Configuration
REQ-031 Macro SEND_SCHED_STALL_EN, when defined, SHALL add a per-QP 4-bit stall counter that increments each cycle qp_req[i] && qp_rts[i] && credit[i]==0 and clears otherwise.
REQ-032 With SEND_SCHED_STALL_EN: sched_err[i] SHALL set when the counter reaches STALL_TIMEOUT, stay set while the stall persists, and clear with the counter; without the macro, sched_err SHALL be tied to 0 and no counters synthesized.

Verification
REQ-033 Reset, all qp_rts=1, qp_req=4'b0101, tx_ready=1 -> grants alternate QP0, QP2, QP0 ...; credits 16->15->14 each; tx_valid 1 cycle after request.
REQ-034 tx_ready held 0 for 5 cycles during SEND, qp_req dropped -> tx_valid/tx_qp stable for 5 cycles; credit decrements only on the ready cycle.
REQ-035 QP1 alone, 16 sends, no ACK -> credit[1]=0, qp_pause[1]=1 one cycle later, no 17th tx_valid; one ACK on QP1 -> credit 1, pause clears, send resumes.
REQ-036 Handshake on QP3 with ack_valid, ack_qp=3 in the same cycle -> credit[3] unchanged; ACK for a QP with qp_rts=0 -> no change.
REQ-037 SEND_SCHED_STALL_EN defined, QP0 at 0 credit with qp_req=1 -> sched_err[0]=1 after 10 stall cycles, clears after an ACK; macro undefined -> sched_err stays 0.
REQ-038 rst pulse while tx_valid=1 -> tx_valid=0 at once, all credits=16, rr_ptr=0.

Source files
------------

// File: rtl/rdma_rc_send_sched_if.sv
// Handshake and status bundle between the RC send scheduler and its QP/PDU-path neighbours.
// master: requester/PDU side; slave: the scheduler.
interface rdma_rc_send_sched_if #(
  parameter int unsigned NUM_QP       = 4,
  parameter int unsigned CREDIT_WIDTH = 8
);
  localparam int unsigned QpW = $clog2(NUM_QP);

  logic [NUM_QP-1:0]              qp_req;
  logic [NUM_QP-1:0]              qp_rts;
  logic                           ack_valid;
  logic [QpW-1:0]                 ack_qp;
  logic                           tx_valid;
  logic [QpW-1:0]                 tx_qp;
  logic                           tx_ready;
  logic [NUM_QP-1:0]              grant;
  logic [NUM_QP*CREDIT_WIDTH-1:0] credit_remain;
  logic [NUM_QP-1:0]              qp_pause;
  logic [NUM_QP-1:0]              sched_err;

  modport master (
    output qp_req, qp_rts, ack_valid, ack_qp, tx_ready,
    input  tx_valid, tx_qp, grant, credit_remain, qp_pause, sched_err
  );

  modport slave (
    input  qp_req, qp_rts, ack_valid, ack_qp, tx_ready,
    output tx_valid, tx_qp, grant, credit_remain, qp_pause, sched_err
  );
endinterface

// File: rtl/rdma_rc_send_sched.sv
// Credit-gated round-robin send scheduler for RC queue pairs.
// Define SEND_SCHED_STALL_EN to add per-QP stall watchdogs driving sched_err.
module rdma_rc_send_sched #(
  parameter int unsigned             NUM_QP        = 4,
  parameter int unsigned             CREDIT_WIDTH  = 8,
  parameter logic [CREDIT_WIDTH-1:0] CREDIT_INIT   = 8'h10,
  parameter logic [3:0]              STALL_TIMEOUT = 4'd10
) (
  input logic                 clk,
  input logic                 rst,
  rdma_rc_send_sched_if.slave bus
);
  localparam int unsigned QpW = $clog2(NUM_QP);

  typedef enum logic {StIdle, StSend} state_e;

  state_e                               state_q, state_d;
  logic [QpW-1:0]                       tx_qp_q, tx_qp_d;
  logic [QpW-1:0]                       rr_ptr_q, rr_ptr_d;
  logic [NUM_QP-1:0][CREDIT_WIDTH-1:0]  credit_q, credit_d;
  logic [NUM_QP-1:0]                    pause_q;

  logic [NUM_QP-1:0] credit_zero;
  logic [NUM_QP-1:0] elig;
  logic [NUM_QP-1:0] dec_vec;
  logic [NUM_QP-1:0] inc_vec;
  logic              any_elig;
  logic [QpW-1:0]    winner;
  logic [QpW-1:0]    idx;
  logic              hs;
  logic              ack_acc;

  assign hs      = (state_q == StSend) && bus.tx_ready;
  assign ack_acc = bus.ack_valid && bus.qp_rts[bus.ack_qp];

  always_comb begin
    for (int i = 0; i < NUM_QP; i++) begin
      credit_zero[i] = (credit_q[i] == '0);
      elig[i]        = bus.qp_req[i] && bus.qp_rts[i] && !credit_zero[i];
      dec_vec[i]     = hs && (tx_qp_q == QpW'(i));
      inc_vec[i]     = ack_acc && (bus.ack_qp == QpW'(i));
    end
  end

  // Scan offsets high-to-low so the smallest offset from rr_ptr wins.
  always_comb begin
    any_elig = 1'b0;
    winner   = '0;
    idx      = '0;
    for (int k = NUM_QP - 1; k >= 0; k--) begin
      idx = rr_ptr_q + QpW'(k);
      if (elig[idx]) begin
        any_elig = 1'b1;
        winner   = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_qp_d  = tx_qp_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (any_elig) begin
          state_d = StSend;
          tx_qp_d = winner;
        end
      end
      StSend: begin
        if (bus.tx_ready) begin
          state_d  = StIdle;
          rr_ptr_d = tx_qp_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A send and an accepted ACK on the same QP cancel out.
  always_comb begin
    for (int i = 0; i < NUM_QP; i++) begin
      credit_d[i] = credit_q[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        if (credit_q[i] != '1) credit_d[i] = credit_q[i] + 1'b1;
      end else if (dec_vec[i] && !inc_vec[i] && !credit_zero[i]) begin
        credit_d[i] = credit_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      tx_qp_q  <= '0;
      rr_ptr_q <= '0;
      pause_q  <= '0;
      for (int i = 0; i < NUM_QP; i++) credit_q[i] <= CREDIT_INIT;
    end else begin
      state_q  <= state_d;
      tx_qp_q  <= tx_qp_d;
      rr_ptr_q <= rr_ptr_d;
      pause_q  <= credit_zero;
      credit_q <= credit_d;
    end
  end

  assign bus.tx_valid      = (state_q == StSend);
  assign bus.tx_qp         = tx_qp_q;
  assign bus.credit_remain = credit_q;
  assign bus.qp_pause      = pause_q;

  always_comb begin
    bus.grant = '0;
    if (state_q == StSend) bus.grant[tx_qp_q] = 1'b1;
  end

`ifdef SEND_SCHED_STALL_EN
  logic [NUM_QP-1:0][3:0] stall_q, stall_d;
  logic [NUM_QP-1:0]      stall_err;

  // Counter saturates at the timeout so the error holds for as long as the stall lasts.
  always_comb begin
    for (int i = 0; i < NUM_QP; i++) begin
      stall_err[i] = (stall_q[i] >= STALL_TIMEOUT);
      if (!(bus.qp_req[i] && bus.qp_rts[i] && credit_zero[i])) begin
        stall_d[i] = '0;
      end else if (stall_err[i]) begin
        stall_d[i] = stall_q[i];
      end else begin
        stall_d[i] = stall_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign bus.sched_err = stall_err;
`else
  logic unused_stall_timeout;
  assign unused_stall_timeout = ^STALL_TIMEOUT;
  assign bus.sched_err        = '0;
`endif

endmodule

// File: tb/tb_rdma_rc_send_sched.sv
// Directed bench for rdma_rc_send_sched; a negedge monitor scores every handshake against
// the queue of expected QP indices pushed by the stimulus.
module tb_rdma_rc_send_sched;
  localparam int unsigned NQ = 4;
  localparam int unsigned CW = 8;
`ifdef SEND_SCHED_STALL_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int unsigned exp_q[$];

  rdma_rc_send_sched_if #(.NUM_QP(NQ), .CREDIT_WIDTH(CW)) bus ();

  rdma_rc_send_sched #(
    .NUM_QP       (NQ),
    .CREDIT_WIDTH (CW),
    .CREDIT_INIT  (8'h10),
    .STALL_TIMEOUT(4'd10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] cr(input int i);
    return bus.credit_remain[i*CW +: CW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    for (int n = 0; n < bound; n++) begin
      step();
      if (exp_q.size() == 0) break;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  // Handshake completes at the next rising edge; inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst && bus.tx_valid && bus.tx_ready) begin
      check("sb_has_entry", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        int unsigned e;
        e = exp_q.pop_front();
        check("sb_tx_qp", 32'(bus.tx_qp), e);
        check("sb_grant", 32'(bus.grant), 32'(1) << e);
      end
    end
  end

  initial begin
    tests         = 0;
    fails         = 0;
    rst           = 1'b1;
    bus.qp_req    = '0;
    bus.qp_rts    = '0;
    bus.ack_valid = 1'b0;
    bus.ack_qp    = '0;
    bus.tx_ready  = 1'b0;
    repeat (3) step();

    check("rst_tx_valid", 32'(bus.tx_valid), 0);
    check("rst_tx_qp", 32'(bus.tx_qp), 0);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_pause", 32'(bus.qp_pause), 0);
    check("rst_err", 32'(bus.sched_err), 0);
    for (int i = 0; i < NQ; i++) check("rst_credit", 32'(cr(i)), 16);
    rst = 1'b0;
    step();

    // Alternating QP0/QP2 with tx_ready high.
    bus.qp_rts   = '1;
    bus.tx_ready = 1'b1;
    bus.qp_req   = 4'b0101;
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(2);
    step();
    check("a_latency_valid", 32'(bus.tx_valid), 1);
    check("a_first_qp", 32'(bus.tx_qp), 0);
    check("a_first_grant", 32'(bus.grant), 32'h1);
    step();
    check("a_gap_valid", 32'(bus.tx_valid), 0);
    check("a_credit0_15", 32'(cr(0)), 15);
    drain(20);
    bus.qp_req = '0;
    check("a_credit0", 32'(cr(0)), 14);
    check("a_credit1", 32'(cr(1)), 16);
    check("a_credit2", 32'(cr(2)), 14);

    // Backpressure: request withdrawn while tx_ready low.
    bus.tx_ready = 1'b0;
    bus.qp_req   = 4'b0010;
    step();
    bus.qp_req = '0;
    for (int k = 0; k < 5; k++) begin
      check("b_hold_valid", 32'(bus.tx_valid), 1);
      check("b_hold_qp", 32'(bus.tx_qp), 1);
      check("b_hold_credit", 32'(cr(1)), 16);
      step();
    end
    exp_q.push_back(1);
    bus.tx_ready = 1'b1;
    step();
    check("b_after_valid", 32'(bus.tx_valid), 0);
    check("b_after_credit", 32'(cr(1)), 15);

    // Exhaust QP1, then revive it with one ACK.
    bus.qp_req = 4'b0010;
    for (int k = 0; k < 15; k++) exp_q.push_back(1);
    drain(80);
    check("c_credit_zero", 32'(cr(1)), 0);
    check("c_pause_not_yet", 32'(bus.qp_pause[1]), 0);
    step();
    check("c_pause_set", 32'(bus.qp_pause[1]), 1);
    for (int k = 0; k < 3; k++) begin
      check("c_no_17th", 32'(bus.tx_valid), 0);
      step();
    end
    exp_q.push_back(1);
    bus.ack_valid = 1'b1;
    bus.ack_qp    = 2'd1;
    step();
    bus.ack_valid = 1'b0;
    check("c_ack_credit", 32'(cr(1)), 1);
    step();
    check("c_pause_clear", 32'(bus.qp_pause[1]), 0);
    check("c_resume_valid", 32'(bus.tx_valid), 1);
    bus.qp_req = '0;
    step();
    check("c_resume_credit", 32'(cr(1)), 0);

    // Same-cycle send and ACK on QP3; ACK on a non-RTS QP; saturation.
    bus.tx_ready = 1'b0;
    bus.qp_req   = 4'b1000;
    step();
    check("d_qp3_valid", 32'(bus.tx_qp), 3);
    exp_q.push_back(3);
    bus.tx_ready  = 1'b1;
    bus.ack_valid = 1'b1;
    bus.ack_qp    = 2'd3;
    step();
    bus.ack_valid = 1'b0;
    bus.qp_req    = '0;
    check("d_cancel_credit", 32'(cr(3)), 16);
    bus.qp_rts    = 4'b1011;
    bus.ack_valid = 1'b1;
    bus.ack_qp    = 2'd2;
    step();
    bus.ack_valid = 1'b0;
    check("d_nonrts_ack", 32'(cr(2)), 14);
    bus.qp_rts    = '1;
    bus.ack_valid = 1'b1;
    bus.ack_qp    = 2'd3;
    repeat (240) step();
    bus.ack_valid = 1'b0;
    check("d_saturate", 32'(cr(3)), 255);

    // Stall watchdog on QP0.
    bus.qp_req = 4'b0001;
    for (int k = 0; k < 14; k++) exp_q.push_back(0);
    drain(80);
    check("e_credit_zero", 32'(cr(0)), 0);
    repeat (9) step();
    check("e_err_before", 32'(bus.sched_err[0]), 0);
    step();
    check("e_err_set", 32'(bus.sched_err[0]), 32'(StallEn));
    repeat (3) step();
    check("e_err_hold", 32'(bus.sched_err[0]), 32'(StallEn));
    exp_q.push_back(0);
    bus.ack_valid = 1'b1;
    bus.ack_qp    = 2'd0;
    step();
    bus.ack_valid = 1'b0;
    check("e_ack_credit", 32'(cr(0)), 1);
    step();
    check("e_err_clear", 32'(bus.sched_err[0]), 0);
    check("e_resume", 32'(bus.tx_valid), 1);
    bus.qp_req = '0;
    step();
    check("e_credit_back", 32'(cr(0)), 0);

    // Reset mid-send discards the pending send.
    bus.tx_ready = 1'b0;
    bus.qp_req   = 4'b0100;
    step();
    check("f_pre_valid", 32'(bus.tx_valid), 1);
    rst = 1'b1;
    #1;
    check("f_rst_valid", 32'(bus.tx_valid), 0);
    check("f_rst_grant", 32'(bus.grant), 0);
    bus.qp_req = '0;
    step();
    rst = 1'b0;
    for (int i = 0; i < NQ; i++) check("f_rst_credit", 32'(cr(i)), 16);
    check("f_rst_pause", 32'(bus.qp_pause), 0);
    bus.tx_ready = 1'b1;
    bus.qp_req   = '1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    drain(20);
    bus.qp_req = '0;
    step();
    check("end_idle", 32'(bus.tx_valid), 0);
    check("end_credit2", 32'(cr(2)), 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
